// File: rtl/processing_element_db.sv
// Weight-stationary systolic PE with double-buffered weight, valid-qualified data flow,
// optional product pipeline stage and saturating/wrapping accumulation with sticky overflow flag.
module processing_element_db #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int MULT_PIPE  = 1,
  parameter int SATURATE   = 1
) (
  input  logic                         CLK,
  input  logic                         ASYNC_RST,
  input  logic                         SYNC_RST,
  input  logic                         EN,
  input  logic                         W_LOAD,
  input  logic                         W_SWAP,
  input  logic signed [DATA_WIDTH-1:0] WeightIn,
  input  logic                         ValidIn,
  input  logic signed [DATA_WIDTH-1:0] DataIn,
  input  logic signed [ACC_WIDTH-1:0]  PsumIn,
  input  logic                         CLR_FLAG,
  output logic signed [DATA_WIDTH-1:0] ToRight,
  output logic                         ValidRight,
  output logic signed [ACC_WIDTH-1:0]  PsumOut,
  output logic                         PsumValid,
  output logic                         SatFlag
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] r_shadow_w;
  logic signed [DATA_WIDTH-1:0] r_active_w;
  logic signed [DATA_WIDTH-1:0] r_to_right;
  logic                         r_valid_right;
  logic signed [ACC_WIDTH-1:0]  r_psum_out;
  logic                         r_psum_valid;
  logic                         r_sat_flag;

  logic signed [PW-1:0]         w_prod;
  logic signed [PW-1:0]         w_s_prod;
  logic signed [ACC_WIDTH-1:0]  w_s_psum;
  logic                         w_s_valid;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic                         w_ovf;
  logic signed [ACC_WIDTH-1:0]  w_result;

  // Operands widened first so -min * -min stays exact.
  assign w_prod = PW'(DataIn) * PW'(r_active_w);

  generate
    if (MULT_PIPE != 0) begin : g_pipe
      logic signed [PW-1:0]        r_pipe_prod;
      logic signed [ACC_WIDTH-1:0] r_pipe_psum;
      logic                        r_pipe_valid;

      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          r_pipe_prod  <= '0;
          r_pipe_psum  <= '0;
          r_pipe_valid <= 1'b0;
        end else if (SYNC_RST) begin
          r_pipe_prod  <= '0;
          r_pipe_psum  <= '0;
          r_pipe_valid <= 1'b0;
        end else if (EN) begin
          r_pipe_prod  <= w_prod;
          r_pipe_psum  <= PsumIn;
          r_pipe_valid <= ValidIn;
        end
      end

      assign w_s_prod  = r_pipe_prod;
      assign w_s_psum  = r_pipe_psum;
      assign w_s_valid = r_pipe_valid;
    end else begin : g_nopipe
      assign w_s_prod  = w_prod;
      assign w_s_psum  = PsumIn;
      assign w_s_valid = ValidIn;
    end
  endgenerate

  assign w_sum = (ACC_WIDTH+1)'(w_s_prod) + (ACC_WIDTH+1)'(w_s_psum);
  assign w_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    w_result = w_sum[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && w_ovf) begin
      w_result = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      r_shadow_w    <= '0;
      r_active_w    <= '0;
      r_to_right    <= '0;
      r_valid_right <= 1'b0;
      r_psum_out    <= '0;
      r_psum_valid  <= 1'b0;
      r_sat_flag    <= 1'b0;
    end else if (SYNC_RST) begin
      r_shadow_w    <= '0;
      r_active_w    <= '0;
      r_to_right    <= '0;
      r_valid_right <= 1'b0;
      r_psum_out    <= '0;
      r_psum_valid  <= 1'b0;
      r_sat_flag    <= 1'b0;
    end else begin
      if (EN) begin
        r_to_right    <= DataIn;
        r_valid_right <= ValidIn;
        if (W_LOAD) r_shadow_w <= WeightIn;
        if (W_SWAP) r_active_w <= r_shadow_w;
        if (w_s_valid) r_psum_out <= w_result;
        r_psum_valid <= w_s_valid;
      end
      // Flag clear stays live while disabled; a fresh overflow beats a clear.
      if (EN && w_s_valid && w_ovf) r_sat_flag <= 1'b1;
      else if (CLR_FLAG)             r_sat_flag <= 1'b0;
    end
  end

  assign ToRight    = r_to_right;
  assign ValidRight = r_valid_right;
  assign PsumOut    = r_psum_out;
  assign PsumValid  = r_psum_valid;
  assign SatFlag    = r_sat_flag;

endmodule

// File: tb/tb_processing_element_db.sv
// Scoreboard bench for processing_element_db: two instances (pipelined+saturating,
// combinational+wrapping) share stimulus; expected results are queued at acceptance.
module tb_processing_element_db;

  logic               CLK = 1'b0;
  logic               ASYNC_RST;
  logic               SYNC_RST;
  logic               EN;
  logic               W_LOAD;
  logic               W_SWAP;
  logic signed [7:0]  WeightIn;
  logic               ValidIn;
  logic signed [7:0]  DataIn;
  logic signed [31:0] PsumIn;
  logic               CLR_FLAG;

  logic [7:0]  to_right  [2];
  logic        valid_rt  [2];
  logic [31:0] psum_out  [2];
  logic        psum_vld  [2];
  logic        sat_flag  [2];

  always #5 CLK = ~CLK;

  processing_element_db #(.DATA_WIDTH(8), .ACC_WIDTH(32), .MULT_PIPE(1), .SATURATE(1)) u_dut_p1s1 (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN), .W_LOAD(W_LOAD),
    .W_SWAP(W_SWAP), .WeightIn(WeightIn), .ValidIn(ValidIn), .DataIn(DataIn), .PsumIn(PsumIn),
    .CLR_FLAG(CLR_FLAG), .ToRight(to_right[0]), .ValidRight(valid_rt[0]), .PsumOut(psum_out[0]),
    .PsumValid(psum_vld[0]), .SatFlag(sat_flag[0]));

  processing_element_db #(.DATA_WIDTH(8), .ACC_WIDTH(32), .MULT_PIPE(0), .SATURATE(0)) u_dut_p0s0 (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN), .W_LOAD(W_LOAD),
    .W_SWAP(W_SWAP), .WeightIn(WeightIn), .ValidIn(ValidIn), .DataIn(DataIn), .PsumIn(PsumIn),
    .CLR_FLAG(CLR_FLAG), .ToRight(to_right[1]), .ValidRight(valid_rt[1]), .PsumOut(psum_out[1]),
    .PsumValid(psum_vld[1]), .SatFlag(sat_flag[1]));

  typedef struct {
    logic        v;
    logic        ovf;
    logic [31:0] val;
  } ent_t;

  ent_t q_p1[$];
  ent_t q_p0[$];

  logic [31:0]       e_psum [2];
  logic              e_pv   [2];
  logic              e_flag [2];
  logic [7:0]        e_tr;
  logic              e_vr;
  logic signed [7:0] m_shadow;
  logic signed [7:0] m_active;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic ent_t model(input logic v, input logic signed [7:0] d,
                                 input logic signed [7:0] w, input logic signed [31:0] p,
                                 input bit sat);
    ent_t   e;
    longint s;
    s     = longint'(d) * longint'(w) + longint'(p);
    e.v   = v;
    e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.val = s[31:0];
    if (sat && e.ovf) e.val = (s > 0) ? 32'h7fff_ffff : 32'h8000_0000;
    return e;
  endfunction

  task automatic model_reset();
    q_p1.delete();
    q_p0.delete();
    q_p1.push_back('{v: 1'b0, ovf: 1'b0, val: 32'h0});
    for (int i = 0; i < 2; i++) begin
      e_psum[i] = '0;
      e_pv[i]   = 1'b0;
      e_flag[i] = 1'b0;
    end
    e_tr = '0;
    e_vr = 1'b0;
    m_shadow = '0;
    m_active = '0;
  endtask

  task automatic apply(input int i, input ent_t pe, input bit clr);
    e_pv[i] = pe.v;
    if (pe.v) e_psum[i] = pe.val;
    if (pe.v && pe.ovf) e_flag[i] = 1'b1;
    else if (clr)       e_flag[i] = 1'b0;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("to_right%0d", i),  64'(to_right[i]), 64'(e_tr));
      check($sformatf("valid_rt%0d", i),  64'(valid_rt[i]), 64'(e_vr));
      check($sformatf("psum_vld%0d", i),  64'(psum_vld[i]), 64'(e_pv[i]));
      check($sformatf("psum_out%0d", i),  64'(psum_out[i]), 64'(e_psum[i]));
      check($sformatf("sat_flag%0d", i),  64'(sat_flag[i]), 64'(e_flag[i]));
    end
  endtask

  task automatic step(input bit en, input bit ld, input bit sw, input int wi, input bit v,
                      input int d, input longint p, input bit clr, input bit srst);
    ent_t ne;
    ent_t pe;
    EN       = en;
    W_LOAD   = ld;
    W_SWAP   = sw;
    WeightIn = 8'(wi);
    ValidIn  = v;
    DataIn   = 8'(d);
    PsumIn   = 32'(p);
    CLR_FLAG = clr;
    SYNC_RST = srst;
    @(posedge CLK);
    if (!ASYNC_RST || srst) begin
      model_reset();
    end else if (en) begin
      ne = model(v, DataIn, m_active, PsumIn, 1'b1);
      q_p1.push_back(ne);
      pe = q_p1.pop_front();
      apply(0, pe, clr);
      ne = model(v, DataIn, m_active, PsumIn, 1'b0);
      q_p0.push_back(ne);
      pe = q_p0.pop_front();
      apply(1, pe, clr);
      e_tr = DataIn;
      e_vr = v;
      if (sw) m_active = m_shadow;
      if (ld) m_shadow = WeightIn;
    end else if (clr) begin
      e_flag[0] = 1'b0;
      e_flag[1] = 1'b0;
    end
    #1 check_all();
  endtask

  task automatic cyc(input bit v, input int d, input longint p);
    step(1'b1, 1'b0, 1'b0, 0, v, d, p, 1'b0, 1'b0);
  endtask

  task automatic set_weight(input int w);
    step(1'b1, 1'b1, 1'b0, w, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    ASYNC_RST = 1'b0;
    SYNC_RST  = 1'b0;
    EN = 1'b0; W_LOAD = 1'b0; W_SWAP = 1'b0; WeightIn = '0;
    ValidIn = 1'b0; DataIn = '0; PsumIn = '0; CLR_FLAG = 1'b0;
    model_reset();
    #12 check_all();
    ASYNC_RST = 1'b1;

    // Latency and bubbles: 2*7, held, 4*7
    set_weight(7);
    cyc(1'b1, 2, 0);
    cyc(1'b0, 9, 0);
    cyc(1'b1, 4, 0);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);

    // Asynchronous reset mid-stream with busy inputs
    cyc(1'b1, 3, 100);
    cyc(1'b1, 5, -7);
    #2 ASYNC_RST = 1'b0;
    EN = 1'b1; W_LOAD = 1'b1; W_SWAP = 1'b1; WeightIn = 8'sd55;
    ValidIn = 1'b1; DataIn = 8'sd9; PsumIn = 32'sd1234;
    model_reset();
    #1 check_all();
    step(1'b1, 1'b1, 1'b1, 55, 1'b1, 9, 1234, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 55, 1'b1, 9, 1234, 1'b0, 1'b0);
    #2 ASYNC_RST = 1'b1;
    cyc(1'b0, 1, 1);
    cyc(1'b0, 1, 1);
    cyc(1'b1, 6, 77);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);

    // Double buffer: 25 through the swap cycle, then 0
    step(1'b1, 1'b1, 1'b0, 3, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 0, 1'b1, 5, 10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, -2, 1'b1, 5, 10, 1'b0, 1'b0);
    cyc(1'b1, 5, 10);
    step(1'b1, 1'b0, 1'b1, 0, 1'b1, 5, 10, 1'b0, 1'b0);
    cyc(1'b1, 5, 10);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);

    // Enable low for three cycles with swap and valid held high
    step(1'b1, 1'b1, 1'b0, 4, 1'b1, 6, 1, 1'b0, 1'b0);
    cyc(1'b1, 7, 2);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 9, 1'b1, 8, 3, 1'b0, 1'b0);
    cyc(1'b1, 8, 3);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);

    // Positive overflow, set-over-clear priority, clear while disabled
    set_weight(127);
    cyc(1'b1, 127, 64'sd2147483548);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 127, 64'sd2147483548, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0);

    // Full-scale product and negative overflow
    set_weight(-128);
    cyc(1'b1, -128, -1);
    cyc(1'b1, 127, -64'sd2147483648);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);

    // Synchronous clear with activity
    cyc(1'b1, 3, 5);
    step(1'b1, 1'b1, 1'b1, 11, 1'b1, 4, 9, 1'b0, 1'b1);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);

    // Mixed random traffic
    for (int k = 0; k < 80; k++) begin
      longint rp;
      rp = longint'($urandom);
      if ($urandom_range(0, 3) == 0) rp = ($urandom_range(0, 1) != 0) ? 64'sd2147450000 : -64'sd2147450000;
      step($urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
           rp, $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
